// File: rtl/xbus_arbiter.sv
// xbus_arbiter: two-master, one-slave arbiter for the xbus.
// m0 (instruction fetch) and m1 (load/store) share a single synchronous-read
// slave. One transaction is accepted per cycle; a shift register remembers
// which master owns each in-flight response so the slave read data can be
// steered back after RD_LATENCY cycles.
`timescale 1ns/1ps

module xbus_arbiter #(
    parameter int unsigned RD_LATENCY = 1,    // slave read latency, legal 1..4
    parameter bit          FIXED_PRIO = 1'b0  // 0: round-robin, 1: m0 wins ties
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        xbus_cs,
    output logic        xbus_we,
    output logic [3:0]  xbus_be,
    output logic [31:0] xbus_addr,
    output logic [31:0] xbus_wdata,
    input  logic [31:0] xbus_rdata
);

    // Index of the master granted most recently (0 = m0, 1 = m1).
    logic last;

    // Response tracking: vld marks a slot carrying a response, own names the
    // master it belongs to. Stage RD_LATENCY-1 lines up with valid rdata.
    logic [RD_LATENCY-1:0] vld;
    logic [RD_LATENCY-1:0] own;

    // Grant decision: combinational, same cycle as the request.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                // Tie: fixed priority favours m0; round-robin favours the
                // master that was not granted last.
                if (FIXED_PRIO || last) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Slave drive: mux the granted master, all-zero when idle so the slave
    // can never see a spurious write. cs follows the grant, which equals
    // m0_req | m1_req whenever reset is released.
    always_comb begin
        xbus_cs    = m0_gnt | m1_gnt;
        xbus_we    = 1'b0;
        xbus_be    = 4'b0000;
        xbus_addr  = 32'h0000_0000;
        xbus_wdata = 32'h0000_0000;
        if (m0_gnt) begin
            xbus_we    = m0_we;
            xbus_be    = m0_be;
            xbus_addr  = m0_addr;
            xbus_wdata = m0_wdata;
        end else if (m1_gnt) begin
            xbus_we    = m1_we;
            xbus_be    = m1_be;
            xbus_addr  = m1_addr;
            xbus_wdata = m1_wdata;
        end
    end

    // Last-grant pointer: resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (m0_gnt || m1_gnt) begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every flop samples pre-edge values regardless of block order.
            last <= m1_gnt;
        end
    end

    // Response shift register: stage 0 captures this cycle's issue, later
    // stages age it by one cycle each.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these tracking flops are reset (unlike a data RAM) because
            // a stale vld bit would raise rvalid for a transaction that was
            // discarded by reset.
            vld <= '0;
            own <= '0;
        end else begin
            vld[0] <= xbus_cs;
            own[0] <= m1_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end

    // Response steering: the oldest stage selects which master sees rvalid.
    assign m0_rvalid = vld[RD_LATENCY-1] && !own[RD_LATENCY-1];
    assign m1_rvalid = vld[RD_LATENCY-1] &&  own[RD_LATENCY-1];

    // Read data is shared and unregistered; only the master with rvalid
    // high samples it, so total read latency is exactly RD_LATENCY.
    assign m0_rdata = xbus_rdata;
    assign m1_rdata = xbus_rdata;

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter: directed scoreboard bench for xbus_arbiter.
// Three instances cover round-robin/latency 1, fixed priority and latency 3.
// Stimulus pushes the expected response (owner, data, arrival cycle) into a
// queue; a per-instance monitor pops and compares whenever an rvalid appears.
`timescale 1ns/1ps

module tb_xbus_arbiter;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        int          inst;
        int          m;
        bit          wr;
        logic [31:0] data;
        int          due;
    } exp_t;

    localparam mreq_t IDLE = '0;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    mreq_t       mst   [3][2];
    logic        gnt   [3][2];
    logic        rv    [3][2];
    logic [31:0] rdat  [3][2];
    logic        cs    [3];
    logic        swe   [3];
    logic [3:0]  sbe   [3];
    logic [31:0] saddr [3];
    logic [31:0] swdata[3];
    logic [31:0] srdata[3];

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to check response arrival time.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic mreq_t rd(logic [31:0] a);
        mreq_t r = '0;
        r.req  = 1'b1;
        r.be   = 4'hF;
        r.addr = a;
        return r;
    endfunction

    function automatic mreq_t wr(logic [31:0] a, logic [3:0] be, logic [31:0] d);
        mreq_t r = '0;
        r.req   = 1'b1;
        r.we    = 1'b1;
        r.be    = be;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int LAT = (g == 2) ? 3 : 1;
            localparam bit FP  = (g == 1);

            logic [31:0] mem  [64];
            logic [31:0] pipe [4];

            xbus_arbiter #(.RD_LATENCY(LAT), .FIXED_PRIO(FP)) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .m0_req     (mst[g][0].req),
                .m0_we      (mst[g][0].we),
                .m0_be      (mst[g][0].be),
                .m0_addr    (mst[g][0].addr),
                .m0_wdata   (mst[g][0].wdata),
                .m0_gnt     (gnt[g][0]),
                .m0_rvalid  (rv[g][0]),
                .m0_rdata   (rdat[g][0]),
                .m1_req     (mst[g][1].req),
                .m1_we      (mst[g][1].we),
                .m1_be      (mst[g][1].be),
                .m1_addr    (mst[g][1].addr),
                .m1_wdata   (mst[g][1].wdata),
                .m1_gnt     (gnt[g][1]),
                .m1_rvalid  (rv[g][1]),
                .m1_rdata   (rdat[g][1]),
                .xbus_cs    (cs[g]),
                .xbus_we    (swe[g]),
                .xbus_be    (sbe[g]),
                .xbus_addr  (saddr[g]),
                .xbus_wdata (swdata[g]),
                .xbus_rdata (srdata[g])
            );

            // Slave model: mem[i] = 0xC0DE0000 + i, byte-enabled writes,
            // read data delivered LAT cycles after cs.
            initial begin
                for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + i;
            end

            always @(posedge clk) begin
                pipe[0] <= mem[saddr[g][7:2]];
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
                if (cs[g] && swe[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sbe[g][b]) mem[saddr[g][7:2]][8*b +: 8] <= swdata[g][8*b +: 8];
                    end
                end
            end

            assign srdata[g] = pipe[LAT-1];

            // Monitor: every rvalid must match the oldest expected response.
            always @(negedge clk) begin
                exp_t e;
                if (rv[g][0] || rv[g][1]) begin
                    check("rvalid_one_hot", {31'b0, rv[g][0] & rv[g][1]}, 32'd0);
                    if (sb_q.size() == 0) begin
                        check("rvalid_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_inst",  g, e.inst);
                        check("rsp_owner", rv[g][1] ? 32'd1 : 32'd0, e.m);
                        check("rsp_cycle", cyc, e.due);
                        if (!e.wr) check("rsp_rdata", rdat[g][e.m], e.data);
                    end
                end
            end
        end
    endgenerate

    // One issue cycle on instance k: drive both masters, check grants and the
    // slave-side mux, and record the response expected for the winner.
    task automatic step(int k, mreq_t r0, mreq_t r1, int exp_g,
                        logic [31:0] exp_d, bit rsp = 1'b1);
        mreq_t sel;
        exp_t  ent;
        @(posedge clk);
        #1;
        mst[k][0] = r0;
        mst[k][1] = r1;
        @(negedge clk);
        check("gnt0", gnt[k][0], exp_g == 0);
        check("gnt1", gnt[k][1], exp_g == 1);
        sel = (exp_g == 0) ? r0 : (exp_g == 1) ? r1 : IDLE;
        check("xbus_cs",    cs[k],     exp_g >= 0);
        check("xbus_we",    swe[k],    sel.we);
        check("xbus_be",    sbe[k],    sel.be);
        check("xbus_addr",  saddr[k],  sel.addr);
        check("xbus_wdata", swdata[k], sel.wdata);
        if (exp_g >= 0 && rsp) begin
            ent.inst = k;
            ent.m    = exp_g;
            ent.wr   = sel.we;
            ent.data = exp_d;
            ent.due  = cyc + lat_of(k);
            sb_q.push_back(ent);
        end
    endtask

    // Wait (bounded) for all expected responses to arrive.
    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with every master requesting: grants and rvalids stay low.
        for (int k = 0; k < 3; k++) begin
            mst[k][0] = rd(32'h0);
            mst[k][1] = rd(32'h4);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_gnt0", gnt[k][0], 32'd0);
            check("rst_gnt1", gnt[k][1], 32'd0);
            check("rst_rv0",  rv[k][0],  32'd0);
            check("rst_rv1",  rv[k][1],  32'd0);
            mst[k][0] = IDLE;
            mst[k][1] = IDLE;
        end
        @(negedge clk);
        rst_n = 1'b1;

        // m0 alone, back-to-back reads of 0x08 and 0x0C.
        step(0, rd(32'h08), IDLE, 0, 32'hC0DE_0002);
        step(0, rd(32'h0C), IDLE, 0, 32'hC0DE_0003);
        step(0, IDLE, IDLE, -1, 32'h0);
        drain();

        // m1 partial write, ack only; then read back the merged word.
        step(0, IDLE, wr(32'h10, 4'b0011, 32'hDEAD_BEEF), 1, 32'h0);
        step(0, IDLE, rd(32'h10), 1, 32'hC0DE_BEEF);
        step(0, IDLE, IDLE, -1, 32'h0);
        drain();

        // Round-robin tie after reset: m0, m1, m0, m1.
        do_reset();
        step(0, rd(32'h20), rd(32'h24), 0, 32'hC0DE_0008);
        step(0, rd(32'h20), rd(32'h24), 1, 32'hC0DE_0009);
        step(0, rd(32'h20), rd(32'h24), 0, 32'hC0DE_0008);
        step(0, rd(32'h20), rd(32'h24), 1, 32'hC0DE_0009);
        step(0, IDLE, IDLE, -1, 32'h0);
        drain();

        // Fixed priority: m0 wins three ties, m1 served once m0 drops.
        step(1, rd(32'h00), rd(32'h0C), 0, 32'hC0DE_0000);
        step(1, rd(32'h04), rd(32'h0C), 0, 32'hC0DE_0001);
        step(1, rd(32'h08), rd(32'h0C), 0, 32'hC0DE_0002);
        step(1, IDLE,       rd(32'h0C), 1, 32'hC0DE_0003);
        step(1, IDLE, IDLE, -1, 32'h0);
        drain();

        // Latency 3: alternating issue, four responses in flight.
        step(2, rd(32'h14), IDLE,       0, 32'hC0DE_0005);
        step(2, IDLE,       rd(32'h18), 1, 32'hC0DE_0006);
        step(2, rd(32'h1C), IDLE,       0, 32'hC0DE_0007);
        step(2, IDLE,       rd(32'h20), 1, 32'hC0DE_0008);
        step(2, IDLE, IDLE, -1, 32'h0);
        drain();

        // Reset mid-flight: m0 granted (last becomes m0), reset next cycle.
        // The in-flight response must vanish and m0 must win the next tie.
        step(2, rd(32'h00), IDLE, 0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        mst[2][0] = rd(32'h04);
        mst[2][1] = rd(32'h08);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_gnt0", gnt[2][0], 32'd0);
            check("midrst_gnt1", gnt[2][1], 32'd0);
            check("midrst_rv0",  rv[2][0],  32'd0);
            check("midrst_rv1",  rv[2][1],  32'd0);
        end
        mst[2][0] = IDLE;
        mst[2][1] = IDLE;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        step(2, rd(32'h04), rd(32'h08), 0, 32'hC0DE_0001);
        step(2, IDLE, IDLE, -1, 32'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
